// File: rtl/zcdc_op_handshake.sv
`timescale 1ns / 1ps
`default_nettype none
// ---------------------------------------------------------------------------
// zcdc_op_handshake: held-data + toggle-request op-code crossing from
// iClk_Global to iClk_Local, with a toggle completion returned. Rev 1.0
// ---------------------------------------------------------------------------
module zcdc_op_handshake #(
  parameter int OP_W        = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic            iClk_Local,
  input  logic            iRst_N,
  input  logic            iClk_Global,
  input  logic            iOp_Valid,
  input  logic [OP_W-1:0] iOp_Code,
  output logic            oOp_Ready,
  output logic            oOp_Done,
  output logic            oOp_Valid,
  output logic [OP_W-1:0] oOp_Code,
  output logic            oOp_Busy,
  input  logic            iOp_Done,
  output logic            oErr_Spurious
);

  typedef enum logic [0:0] { G_IDLE = 1'b0, G_WAIT = 1'b1 } g_state_e;
  typedef enum logic [0:0] { L_IDLE = 1'b0, L_BUSY = 1'b1 } l_state_e;

  // Global-domain state
  g_state_e                g_state_q;
  logic [OP_W-1:0]         hold_q;
  logic                    req_tog_q;
  logic                    op_ready_q;
  logic                    op_done_q;
  logic                    done_dly_q;
  (* ASYNC_REG = "TRUE" *)
  logic [SYNC_STAGES-1:0]  done_sync_q;
  logic                    done_edge;

  // Local-domain state
  l_state_e                l_state_q;
  logic [OP_W-1:0]         code_q;
  logic                    done_tog_q;
  logic                    op_valid_q;
  logic                    busy_q;
  logic                    err_q;
  logic                    req_dly_q;
  (* ASYNC_REG = "TRUE" *)
  logic [SYNC_STAGES-1:0]  req_sync_q;
  logic                    req_edge;

  // ---------------------------------------------------------------- global
  always_ff @(posedge iClk_Global or negedge iRst_N) begin
    if (!iRst_N) begin
      done_sync_q <= '0;
    end else begin
      done_sync_q <= {done_sync_q[SYNC_STAGES-2:0], done_tog_q};
    end
  end

  assign done_edge = done_sync_q[SYNC_STAGES-1] ^ done_dly_q;

  always_ff @(posedge iClk_Global or negedge iRst_N) begin
    if (!iRst_N) begin
      g_state_q  <= G_IDLE;
      hold_q     <= '0;
      req_tog_q  <= 1'b0;
      op_ready_q <= 1'b1;
      op_done_q  <= 1'b0;
      done_dly_q <= 1'b0;
    end else begin
      done_dly_q <= done_sync_q[SYNC_STAGES-1];
      op_done_q  <= 1'b0;
      case (g_state_q)
        G_IDLE: begin
          if (iOp_Valid) begin
            hold_q     <= iOp_Code;
            req_tog_q  <= ~req_tog_q;
            op_ready_q <= 1'b0;
            g_state_q  <= G_WAIT;
          end
        end
        G_WAIT: begin
          // hold_q stays frozen here; the local side samples it directly.
          if (done_edge) begin
            op_done_q  <= 1'b1;
            op_ready_q <= 1'b1;
            g_state_q  <= G_IDLE;
          end
        end
        default: begin
          op_ready_q <= 1'b1;
          g_state_q  <= G_IDLE;
        end
      endcase
    end
  end

  assign oOp_Ready = op_ready_q;
  assign oOp_Done  = op_done_q;

  // ----------------------------------------------------------------- local
  always_ff @(posedge iClk_Local or negedge iRst_N) begin
    if (!iRst_N) begin
      req_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_tog_q};
    end
  end

  assign req_edge = req_sync_q[SYNC_STAGES-1] ^ req_dly_q;

  always_ff @(posedge iClk_Local or negedge iRst_N) begin
    if (!iRst_N) begin
      l_state_q  <= L_IDLE;
      code_q     <= '0;
      done_tog_q <= 1'b0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      req_dly_q  <= 1'b0;
    end else begin
      req_dly_q  <= req_sync_q[SYNC_STAGES-1];
      op_valid_q <= 1'b0;
      case (l_state_q)
        L_IDLE: begin
          if (iOp_Done) begin
            err_q <= 1'b1;
          end
          if (req_edge) begin
            code_q     <= hold_q;
            op_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            l_state_q  <= L_BUSY;
          end
        end
        L_BUSY: begin
          if (iOp_Done) begin
            done_tog_q <= ~done_tog_q;
            busy_q     <= 1'b0;
            l_state_q  <= L_IDLE;
          end
        end
        default: begin
          busy_q    <= 1'b0;
          l_state_q <= L_IDLE;
        end
      endcase
    end
  end

  assign oOp_Valid     = op_valid_q;
  assign oOp_Code      = code_q;
  assign oOp_Busy      = busy_q;
  assign oErr_Spurious = err_q;

endmodule

`default_nettype wire

// File: tb/tb_zcdc_op_handshake.sv
`timescale 1ns / 1ps
`default_nettype none
// tb_zcdc_op_handshake: directed phases with randomized codes/engine delays,
// checked against an accepted-code queue and in-flight model.
module tb_zcdc_op_handshake;

  localparam int OP_W        = 8;
  localparam int SYNC_STAGES = 2;

  logic            gclk      = 1'b0;
  logic            lclk      = 1'b0;
  int              g_half    = 5;
  int              l_half    = 15;
  logic            rst_n     = 1'b0;
  logic            iop_valid = 1'b0;
  logic [OP_W-1:0] iop_code  = '0;
  logic            iop_done  = 1'b0;
  logic            o_ready;
  logic            o_done;
  logic            o_valid;
  logic [OP_W-1:0] o_code;
  logic            o_busy;
  logic            o_err;

  int n_checks = 0;
  int n_fail   = 0;

  zcdc_op_handshake #(.OP_W(OP_W), .SYNC_STAGES(SYNC_STAGES)) u_dut (
    .iClk_Local   (lclk),
    .iRst_N       (rst_n),
    .iClk_Global  (gclk),
    .iOp_Valid    (iop_valid),
    .iOp_Code     (iop_code),
    .oOp_Ready    (o_ready),
    .oOp_Done     (o_done),
    .oOp_Valid    (o_valid),
    .oOp_Code     (o_code),
    .oOp_Busy     (o_busy),
    .iOp_Done     (iop_done),
    .oErr_Spurious(o_err)
  );

  initial forever #(g_half) gclk = ~gclk;
  initial forever #(l_half) lclk = ~lclk;

  // Global-side model: an op is accepted when requested and none is in flight.
  logic [OP_W-1:0] exp_codes [0:63];
  int  wr_idx     = 0;
  int  n_acc      = 0;
  int  n_done     = 0;
  int  ready_err  = 0;
  int  done_unexp = 0;
  bit  m_inflight = 1'b0;
  time t_acc      = 0;

  initial forever begin
    @(posedge gclk);
    if (rst_n && iop_valid && !m_inflight) begin
      exp_codes[wr_idx[5:0]] = iop_code;
      wr_idx++;
      n_acc++;
      m_inflight = 1'b1;
      t_acc = $time;
    end
    #2;
    if (!rst_n) begin
      m_inflight = 1'b0;
    end else begin
      if (o_done) begin
        if (!m_inflight) done_unexp++;
        m_inflight = 1'b0;
        n_done++;
      end
      if (o_ready !== !m_inflight) ready_err++;
    end
  end

  // Local side: delivered-code scoreboard plus a processing engine.
  logic [OP_W-1:0] vlog [0:63];
  int  rd_idx        = 0;
  int  n_valid       = 0;
  int  code_err      = 0;
  int  vb_err        = 0;
  int  busy_run      = 0;
  int  last_busy_len = 0;
  int  eng_cnt       = -1;
  int  eng_delay     = 3;
  int  spur_cnt      = 0;
  int  spur_done     = 0;
  time t_valid       = 0;

  initial forever begin
    @(negedge lclk);
    if (iop_done) iop_done = 1'b0;
    if (!rst_n) begin
      eng_cnt  = -1;
      rd_idx   = wr_idx;
      busy_run = 0;
    end else begin
      if (o_busy) begin
        busy_run++;
      end else begin
        if (busy_run != 0) last_busy_len = busy_run;
        busy_run = 0;
      end
      if (o_valid) begin
        vlog[n_valid[5:0]] = o_code;
        n_valid++;
        t_valid = $time;
        if (!o_busy) vb_err++;
        if (rd_idx == wr_idx) begin
          code_err++;
        end else begin
          if (o_code !== exp_codes[rd_idx[5:0]]) code_err++;
          rd_idx++;
        end
        eng_cnt = (eng_delay < 0) ? int'($urandom_range(0, 4)) : eng_delay;
      end
      if (spur_cnt != spur_done) begin
        iop_done = 1'b1;
        spur_done++;
      end else if (eng_cnt == 0) begin
        iop_done = 1'b1;
        eng_cnt  = -1;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gstep(input int n);
    repeat (n) begin
      @(posedge gclk);
      #3;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    chk({tag, "_done"},  32'(o_done),  32'd0);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_code"},  32'(o_code),  32'd0);
    chk({tag, "_busy"},  32'(o_busy),  32'd0);
    chk({tag, "_err"},   32'(o_err),   32'd0);
  endtask

  task automatic run_op(input logic [OP_W-1:0] code, input string tag);
    int v0 = n_valid;
    int d0 = n_done;
    int k  = 0;
    iop_valid = 1'b1;
    iop_code  = code;
    gstep(1);
    iop_valid = 1'b0;
    while (n_done == d0 && k < 400) begin
      gstep(1);
      k++;
    end
    chk({tag, "_done_cnt"},  32'(n_done - d0),  32'd1);
    chk({tag, "_valid_cnt"}, 32'(n_valid - v0), 32'd1);
    chk({tag, "_code"},      32'(vlog[v0[5:0]]), 32'(code));
  endtask

  task automatic stream(input logic [OP_W-1:0] c0, input logic [OP_W-1:0] c1,
                        input logic [OP_W-1:0] c2, input bit scramble, input string tag);
    logic [OP_W-1:0] codes [3];
    int v0  = n_valid;
    int d0  = n_done;
    int a0  = n_acc;
    int idx = 0;
    int k   = 0;
    codes[0] = c0;
    codes[1] = c1;
    codes[2] = c2;
    iop_valid = 1'b1;
    iop_code  = codes[0];
    while (idx < 3 && k < 1000) begin
      gstep(1);
      k++;
      if (o_done) begin
        idx++;
        if (idx < 3) iop_code = codes[idx];
        else         iop_valid = 1'b0;
      end else if (scramble) begin
        iop_code = OP_W'($urandom);
      end
    end
    iop_valid = 1'b0;
    chk({tag, "_done_cnt"},  32'(n_done - d0),  32'd3);
    chk({tag, "_valid_cnt"}, 32'(n_valid - v0), 32'd3);
    chk({tag, "_acc_cnt"},   32'(n_acc - a0),   32'd3);
    for (int i = 0; i < 3; i++) begin
      int vi = v0 + i;
      chk($sformatf("%s_code%0d", tag, i), 32'(vlog[vi[5:0]]), 32'(codes[i]));
    end
  endtask

  initial begin
    int lat;
    int d0;
    int v0;
    int k;
    logic [OP_W-1:0] r0, r1, r2;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge gclk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    gstep(4);

    // Ratio 1:3, single op, engine completes after a few local cycles
    eng_delay = 3;
    run_op(8'h05, "r13");
    lat = int'(t_valid - t_acc);
    chk("r13_latency", 32'((lat > SYNC_STAGES * 2 * l_half) &&
                           (lat <= (SYNC_STAGES + 2) * 2 * l_half + l_half)), 32'd1);
    chk("r13_ready_after", 32'(o_ready), 32'd1);

    // Ratio 4:1 (local faster), valid held high across three ops
    g_half = 20;
    l_half = 5;
    eng_delay = -1;
    gstep(3);
    stream(8'hA5, 8'h3C, 8'hFF, 1'b0, "r41");

    // Code scrambled every global cycle while waiting
    g_half = 7;
    l_half = 11;
    gstep(3);
    r0 = OP_W'($urandom);
    r1 = OP_W'($urandom);
    r2 = OP_W'($urandom);
    stream(r0, r1, r2, 1'b1, "scr");

    // Spurious completion while idle
    g_half = 5;
    l_half = 15;
    eng_delay = 2;
    gstep(6);
    chk("spur_pre_err", 32'(o_err), 32'd0);
    d0 = n_done;
    spur_cnt++;
    gstep(15);
    chk("spur_err", 32'(o_err), 32'd1);
    chk("spur_no_done", 32'(n_done - d0), 32'd0);
    run_op(8'h5A, "spur_next");
    chk("spur_sticky", 32'(o_err), 32'd1);

    // Completion in the same cycle as the valid pulse
    eng_delay = 0;
    run_op(8'hC3, "same");
    gstep(2);
    chk("same_busy_len", 32'(last_busy_len), 32'd1);

    // Reset while the op is in flight
    eng_delay = 20;
    v0 = n_valid;
    iop_valid = 1'b1;
    iop_code  = 8'h77;
    gstep(1);
    iop_valid = 1'b0;
    k = 0;
    while (n_valid == v0 && k < 100) begin
      gstep(1);
      k++;
    end
    chk("rmid_valid_seen", 32'(n_valid - v0), 32'd1);
    chk("rmid_ready_low", 32'(o_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rmid");
    d0 = n_done;
    v0 = n_valid;
    gstep(6);
    rst_n = 1'b1;
    gstep(20);
    chk("rmid_no_stale_done", 32'(n_done - d0), 32'd0);
    chk("rmid_no_stale_valid", 32'(n_valid - v0), 32'd0);
    eng_delay = 2;
    run_op(8'h02, "post_rst");

    // Continuous monitors
    chk("mon_code_err", 32'(code_err), 32'd0);
    chk("mon_valid_busy_err", 32'(vb_err), 32'd0);
    chk("mon_ready_err", 32'(ready_err), 32'd0);
    chk("mon_done_unexpected", 32'(done_unexp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/zcdc_op_handshake.md
Name: zcdc_op_handshake

Overview:
- Parametrised, handshake-safe successor to the two-flop op-code/done crossing between the iClk_Global and iClk_Local domains.
- Carries an OP_W-bit op-code from the global domain to the local domain using a held data register plus a toggle request. Multi-bit data is never synchronised directly.
- Returns a completion toggle to the global domain, with ready/valid flow control on the global side.
- Sits between the global sequencer and a local-domain processing engine.

Parameters:
- OP_W, 3, op-code width in bits (1..32).
- SYNC_STAGES, 2, synchroniser flops per crossing (2..4).

Ports:
- iClk_Local  in  1  local clock; clocks the local-side logic. This is the block's primary clock.
- iRst_N  in  1  reset, asynchronous, active-low. Deassertion is already synchronised to both clocks upstream.
- iClk_Global  in  1  global clock; clocks the source-side logic.
- iOp_Valid  in  1  global: op-code request.
- iOp_Code  in  OP_W  global: op-code, sampled when iOp_Valid && oOp_Ready.
- oOp_Ready  out  1  global: high when no op is in flight.
- oOp_Done  out  1  global: 1-cycle pulse when the local completion arrives.
- oOp_Valid  out  1  local: 1-cycle pulse, new op available.
- oOp_Code  out  OP_W  local: op-code, stable from the oOp_Valid pulse until the next op.
- oOp_Busy  out  1  local: high from the oOp_Valid pulse until iOp_Done is accepted.
- iOp_Done  in  1  local: completion pulse from the engine.
- oErr_Spurious  out  1  local: sticky flag, set when iOp_Done arrives while not busy.

Behaviour:
- Reset values: all registers 0. Outputs: oOp_Ready=1, oOp_Done=0, oOp_Valid=0, oOp_Code=0, oOp_Busy=0, oErr_Spurious=0. Toggles and all synchroniser chains clear. Reset mid-operation discards the in-flight op; no oOp_Done is produced for it.
- Global FSM states: G_IDLE and G_WAIT.
  - G_IDLE: oOp_Ready=1. When iOp_Valid=1, latch iOp_Code into hold_reg (global domain), invert req_tog, and go to G_WAIT.
  - G_WAIT: oOp_Ready=0; iOp_Valid is ignored. hold_reg must not change in this state.
  - On an edge of done_sync (done_tog after SYNC_STAGES global flops; edge = last stage XOR one extra delay flop): pulse oOp_Done for 1 cycle and return to G_IDLE. oOp_Ready=1 in the same cycle as the oOp_Done pulse.
- Local side:
  - req_tog passes through SYNC_STAGES local flops plus one edge-detect flop.
  - Edge detected: capture hold_reg into oOp_Code, pulse oOp_Valid, set oOp_Busy.
  - hold_reg is stable for at least SYNC_STAGES+1 local cycles before capture, so the capture is metastability-free by construction.
- Local FSM states: L_IDLE and L_BUSY.
  - L_IDLE: on a request edge, go to L_BUSY.
  - L_BUSY: when iOp_Done=1, invert done_tog, clear oOp_Busy, go to L_IDLE.
  - iOp_Done=1 in L_IDLE: set oErr_Spurious; done_tog does not toggle. The flag clears only on reset.
  - iOp_Done in the same cycle as the oOp_Valid pulse is legal and is accepted.
- Latency:
  - Global accept to local oOp_Valid: SYNC_STAGES+1 or SYNC_STAGES+2 local edges (phase dependent).
  - Local done to global oOp_Done: SYNC_STAGES+1 or SYNC_STAGES+2 global edges.
  - Minimum back-to-back op period: one full round trip.
- Clock ratios: any ratio is allowed, because the toggle protocol is level-based; each toggle holds until it is acknowledged. At most one op is in flight.
- Width rules: oOp_Code and hold_reg are exactly OP_W bits with no extension. Synchroniser flops carry the attribute the team uses for ASYNC_REG/no-retiming.

Test Plan:
- Ratio 1:3 (global 100 MHz, local 33 MHz), OP_W=3, code 3'b101 → oOp_Valid pulses once with oOp_Code=3'b101 within 4 local edges. oOp_Ready stays 0 until iOp_Done is asserted, then oOp_Done pulses once and oOp_Ready=1.
- Ratio 4:1 (local faster), OP_W=8, codes 0xA5, 0x3C, 0xFF with iOp_Valid held high continuously → exactly three oOp_Valid pulses carrying those codes in order. No extra acceptance occurs while oOp_Ready=0.
- iOp_Code changed every global cycle while in G_WAIT → oOp_Code keeps the accepted value; no corruption.
- iOp_Done pulsed in L_IDLE → oErr_Spurious=1 (sticky), no oOp_Done, and the next normal op still completes.
- iOp_Done asserted in the same cycle as oOp_Valid → op completes, oOp_Busy is 1 for exactly one cycle, and a single oOp_Done pulse follows.
- iRst_N asserted in G_WAIT/L_BUSY → all outputs at reset values immediately (asynchronously). After release, a fresh op with code 3'b010 completes normally with no stale oOp_Valid or oOp_Done.
